showdown_ranker: RTL and testbench
==================================

SHOWDOWN_RANKER -- requirements
Module: showdown_ranker

Interface
REQ-001 Parameter N_PLAYER, default 9, number of players evaluated (legal range 2..9).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 in_valid  input  1  one-cycle strobe qualifying all card inputs.
REQ-005 in_hole_num  input  8*N_PLAYER  hole card ranks; player p card c at bits [(2p+c)*4 +: 4].
REQ-006 in_hole_suit  input  4*N_PLAYER  hole card suits; player p card c at bits [(2p+c)*2 +: 2].
REQ-007 in_pub_num  input  20  five board ranks; card i at [i*4 +: 4].
REQ-008 in_pub_suit  input  10  five board suits; card i at [i*2 +: 2].
REQ-009 out_valid  output  1  high for exactly one cycle per accepted hand.
REQ-010 out_winner  output  N_PLAYER  bit p set if player p holds the maximal score.
REQ-011 Rank encoding 1=Ace, 2..13 face value; suit encoding 0..3; all 5+2N cards distinct by contract.

Function
REQ-012 States: IDLE, EVAL, DONE; reset state IDLE.
REQ-013 IDLE: in_valid=1 registers all card inputs, clears player index and best score, moves to EVAL.
REQ-014 EVAL: one player per cycle, index 0..N_PLAYER-1, 7-card score of the indexed player computed and compared against the running best.
REQ-015 Score is 8 bits, {category[3:0], key[3:0]}, compared unsigned.
REQ-016 Categories: 0 high card, 1 pair, 2 two pair, 3 trips, 4 straight, 5 flush, 6 full house, 7 quads, 8 straight flush.
REQ-017 Key: Ace = 14 internally; straight and straight flush = top card (A-2-3-4-5 top = 5); flush = highest card of the flush suit; quads, trips and full house = rank of the highest trips or quads; two pair and pair = highest pair; high card = highest rank.
REQ-018 Running winner mask: score > best replaces the mask with one-hot p; score == best ORs in bit p; score < best leaves it unchanged.
REQ-019 After index N_PLAYER-1 the FSM moves to DONE; DONE drives out_valid=1 and out_winner=mask, then returns to IDLE.
REQ-020 Latency: out_valid rises exactly N_PLAYER+1 cycles after the in_valid cycle.
REQ-021 out_winner is all-zero whenever out_valid=0.
REQ-022 in_valid during EVAL or DONE is ignored; no queuing.
REQ-023 in_valid in the cycle after DONE (IDLE) is accepted normally.
REQ-024 Duplicate-card input is outside the contract, but out_valid timing still holds.

Reset
REQ-025 rst_n=0 at any edge forces IDLE, out_valid=0, out_winner=0, and clears index, best score and mask.
REQ-026 Reset during EVAL aborts the hand; no out_valid is produced for it.

Configuration
REQ-027 Macro SHOWDOWN_SCORE_OUT_EN defined: extra output out_best_score (8 bits) carries the winning score while out_valid=1 and zero otherwise.
REQ-028 Macro SHOWDOWN_SCORE_OUT_EN undefined: the port and its register are absent; all other behaviour is identical.

Structure
REQ-029 Shared package poker_pkg holds the card typedef (rank, suit), category enum, score typedef, MAX_PLAYER=9 and ACE_HIGH=14.
REQ-030 Sub-module poker_hand_eval is a purely combinational 7-card to score block, instantiated once and time-multiplexed by the player index.

Verification
REQ-031 Bench holds rst_n=0 for 3 cycles -> out_valid=0 and out_winner=0 throughout; FSM is in IDLE after release.
REQ-032 Bench drives N=2, board A0 K0 Q0 2-1 3-2, p0 J0 10-0, p1 A1 A2 -> p0 scores 0x8E, p1 scores 0x3E; out_winner=2'b01 exactly 3 cycles after in_valid.
REQ-033 Bench drives N=2, board A3 2-2 3-1 9-0 K3, p0 4-0 5-1, p1 K2 K1 -> p0 scores 0x45 (wheel) and beats p1 at 0x3D; out_winner=2'b01.
REQ-034 Bench drives N=2, board 10-3 J2 Q1 K0 A3, p0 2-2 3-1, p1 4-1 5-2 -> both score 0x4E; out_winner=2'b11.
REQ-035 Bench drives N=9 with a second in_valid 4 cycles after the first -> exactly one out_valid, 10 cycles after the first strobe; the second strobe is dropped.
REQ-036 Bench drives rst_n=0 two cycles after in_valid -> out_valid never asserts; a fresh hand afterwards completes with normal latency.

Source files
------------

// File: rtl/poker_pkg.sv
// rtl/poker_pkg.sv - shared card, category and score types plus rank-mask helpers for the showdown ranker
package poker_pkg;

   localparam int         MAX_PLAYER = 9;
   localparam logic [3:0] ACE_HIGH   = 4'd14;

   typedef struct packed {
      logic [3:0] rank;
      logic [1:0] suit;
   } card_t;

   typedef enum logic [3:0] {
      CAT_HIGH_CARD      = 4'd0,
      CAT_PAIR           = 4'd1,
      CAT_TWO_PAIR       = 4'd2,
      CAT_TRIPS          = 4'd3,
      CAT_STRAIGHT       = 4'd4,
      CAT_FLUSH          = 4'd5,
      CAT_FULL_HOUSE     = 4'd6,
      CAT_QUADS          = 4'd7,
      CAT_STRAIGHT_FLUSH = 4'd8
   } category_e;

   typedef logic [7:0] score_t;

   // Bit r of a rank mask marks rank r (2..14); bit 1 is filled from the ace so A-2-3-4-5 tops at 5.
   function automatic logic [3:0] straight_top(input logic [15:0] mask);
      logic [15:0] m;
      m    = mask;
      m[1] = mask[14];
      straight_top = 4'd0;
      for (int t = 5; t <= 14; t++)
         if (&m[t -: 5]) straight_top = 4'(t);
   endfunction

   function automatic logic [3:0] top_rank(input logic [15:0] mask);
      top_rank = 4'd0;
      for (int r = 2; r <= 14; r++)
         if (mask[r]) top_rank = 4'(r);
   endfunction

endpackage

// File: rtl/poker_hand_eval.sv
// rtl/poker_hand_eval.sv - combinational 7-card scorer producing {category, key}
module poker_hand_eval
   import poker_pkg::*;
(
   input  logic [27:0] card_num,
   input  logic [13:0] card_suit,
   output logic [7:0]  score
);

   card_t       cards [7];
   logic [2:0]  rank_cnt [16];
   logic [2:0]  suit_cnt [4];
   logic [15:0] suit_mask [4];
   logic [15:0] rank_mask;
   logic [15:0] pair_mask;
   logic [15:0] trip_mask;
   logic [15:0] quad_mask;
   logic [15:0] flush_mask;
   logic [3:0]  pair_num;
   logic        has_flush;
   logic [3:0]  st_top;
   logic [3:0]  sf_top;
   category_e   cat;
   logic [3:0]  key;

   always_comb begin
      for (int i = 0; i < 7; i++) begin
         cards[i].rank = (card_num[i*4 +: 4] == 4'd1) ? ACE_HIGH : card_num[i*4 +: 4];
         cards[i].suit = card_suit[i*2 +: 2];
      end
   end

   always_comb begin
      for (int r = 0; r < 16; r++) rank_cnt[r] = 3'd0;
      for (int s = 0; s < 4; s++) begin
         suit_cnt[s]  = 3'd0;
         suit_mask[s] = '0;
      end
      rank_mask = '0;
      for (int i = 0; i < 7; i++) begin
         rank_cnt[cards[i].rank]                  = rank_cnt[cards[i].rank] + 3'd1;
         suit_cnt[cards[i].suit]                  = suit_cnt[cards[i].suit] + 3'd1;
         rank_mask[cards[i].rank]                 = 1'b1;
         suit_mask[cards[i].suit][cards[i].rank]  = 1'b1;
      end
   end

   always_comb begin
      pair_mask  = '0;
      trip_mask  = '0;
      quad_mask  = '0;
      pair_num   = 4'd0;
      has_flush  = 1'b0;
      flush_mask = '0;
      for (int r = 2; r <= 14; r++) begin
         pair_mask[r] = (rank_cnt[r] >= 3'd2);
         trip_mask[r] = (rank_cnt[r] >= 3'd3);
         quad_mask[r] = (rank_cnt[r] >= 3'd4);
         if (rank_cnt[r] >= 3'd2) pair_num = pair_num + 4'd1;
      end
      for (int s = 0; s < 4; s++) begin
         if (suit_cnt[s] >= 3'd5) begin
            has_flush  = 1'b1;
            flush_mask = suit_mask[s];
         end
      end
      st_top = straight_top(rank_mask);
      sf_top = straight_top(flush_mask);

      // Highest category wins; a second trips counts as the pair of a full house.
      if (sf_top != 4'd0) begin
         cat = CAT_STRAIGHT_FLUSH;
         key = sf_top;
      end else if (quad_mask != '0) begin
         cat = CAT_QUADS;
         key = top_rank(quad_mask);
      end else if ((trip_mask != '0) && (pair_num >= 4'd2)) begin
         cat = CAT_FULL_HOUSE;
         key = top_rank(trip_mask);
      end else if (has_flush) begin
         cat = CAT_FLUSH;
         key = top_rank(flush_mask);
      end else if (st_top != 4'd0) begin
         cat = CAT_STRAIGHT;
         key = st_top;
      end else if (trip_mask != '0) begin
         cat = CAT_TRIPS;
         key = top_rank(trip_mask);
      end else if (pair_num >= 4'd2) begin
         cat = CAT_TWO_PAIR;
         key = top_rank(pair_mask);
      end else if (pair_mask != '0) begin
         cat = CAT_PAIR;
         key = top_rank(pair_mask);
      end else begin
         cat = CAT_HIGH_CARD;
         key = top_rank(rank_mask);
      end
      score = {cat, key};
   end

endmodule

// File: rtl/showdown_ranker.sv
// rtl/showdown_ranker.sv - sequential showdown winner finder; SHOWDOWN_SCORE_OUT_EN adds out_best_score
module showdown_ranker
   import poker_pkg::*;
#(
   parameter int N_PLAYER = 9
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [8*N_PLAYER-1:0] in_hole_num,
   input  logic [4*N_PLAYER-1:0] in_hole_suit,
   input  logic [19:0]           in_pub_num,
   input  logic [9:0]            in_pub_suit,
   output logic                  out_valid,
   output logic [N_PLAYER-1:0]   out_winner
`ifdef SHOWDOWN_SCORE_OUT_EN
   ,
   output logic [7:0]            out_best_score
`endif
);

   localparam int IDX_W = $clog2(MAX_PLAYER);

   typedef enum logic [1:0] {IDLE, EVAL, DONE} state_e;

   state_e                state_q;
   state_e                state_d;
   logic [IDX_W-1:0]      idx_q;
   logic [8*N_PLAYER-1:0] hole_num_q;
   logic [4*N_PLAYER-1:0] hole_suit_q;
   logic [19:0]           pub_num_q;
   logic [9:0]            pub_suit_q;
   score_t                best_q;
   score_t                cur_score;
   logic [N_PLAYER-1:0]   mask_q;
   logic [N_PLAYER-1:0]   idx_onehot;
   logic [7:0]            cur_num;
   logic [3:0]            cur_suit;
   logic                  last_player;

   assign last_player = (idx_q == IDX_W'(N_PLAYER - 1));

   // One evaluator shared across players: select the indexed player's hole cards.
   always_comb begin
      cur_num    = '0;
      cur_suit   = '0;
      idx_onehot = '0;
      for (int p = 0; p < N_PLAYER; p++) begin
         if (idx_q == IDX_W'(p)) begin
            cur_num       = hole_num_q[p*8 +: 8];
            cur_suit      = hole_suit_q[p*4 +: 4];
            idx_onehot[p] = 1'b1;
         end
      end
   end

   poker_hand_eval u_eval (
      .card_num  ({cur_num, pub_num_q}),
      .card_suit ({cur_suit, pub_suit_q}),
      .score     (cur_score)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      out_valid  = 1'b0;
      out_winner = '0;
`ifdef SHOWDOWN_SCORE_OUT_EN
      out_best_score = '0;
`endif
      case (state_q)
         IDLE: if (in_valid) state_d = EVAL;
         EVAL: if (last_player) state_d = DONE;
         DONE: begin
            state_d    = IDLE;
            out_valid  = 1'b1;
            out_winner = mask_q;
`ifdef SHOWDOWN_SCORE_OUT_EN
            out_best_score = best_q;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q       <= '0;
         best_q      <= '0;
         mask_q      <= '0;
         hole_num_q  <= '0;
         hole_suit_q <= '0;
         pub_num_q   <= '0;
         pub_suit_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  hole_num_q  <= in_hole_num;
                  hole_suit_q <= in_hole_suit;
                  pub_num_q   <= in_pub_num;
                  pub_suit_q  <= in_pub_suit;
                  idx_q       <= '0;
                  best_q      <= '0;
                  mask_q      <= '0;
               end
            end
            EVAL: begin
               idx_q <= idx_q + IDX_W'(1);
               if (cur_score > best_q) begin
                  best_q <= cur_score;
                  mask_q <= idx_onehot;
               end else if (cur_score == best_q) begin
                  mask_q <= mask_q | idx_onehot;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_showdown_ranker.sv
// tb/tb_showdown_ranker.sv - directed checks of showdown_ranker (2 and 9 players) and its hand evaluator
module tb_showdown_ranker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;

   logic        in_valid2 = 1'b0;
   logic [15:0] hole_num2 = '0;
   logic [7:0]  hole_suit2 = '0;
   logic [19:0] pub_num2 = '0;
   logic [9:0]  pub_suit2 = '0;
   logic        out_valid2;
   logic [1:0]  out_winner2;

   logic        in_valid9 = 1'b0;
   logic [71:0] hole_num9 = '0;
   logic [35:0] hole_suit9 = '0;
   logic [19:0] pub_num9 = '0;
   logic [9:0]  pub_suit9 = '0;
   logic        out_valid9;
   logic [8:0]  out_winner9;

`ifdef SHOWDOWN_SCORE_OUT_EN
   logic [7:0]  out_best_score2;
   logic [7:0]  out_best_score9;
`endif

   logic [27:0] ev_num = '0;
   logic [13:0] ev_suit = '0;
   logic [7:0]  ev_score;

   int n_checks = 0;
   int n_pass   = 0;

   showdown_ranker #(.N_PLAYER(2)) dut2 (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid2),
      .in_hole_num  (hole_num2),
      .in_hole_suit (hole_suit2),
      .in_pub_num   (pub_num2),
      .in_pub_suit  (pub_suit2),
      .out_valid    (out_valid2),
      .out_winner   (out_winner2)
`ifdef SHOWDOWN_SCORE_OUT_EN
      ,
      .out_best_score (out_best_score2)
`endif
   );

   showdown_ranker dut9 (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid9),
      .in_hole_num  (hole_num9),
      .in_hole_suit (hole_suit9),
      .in_pub_num   (pub_num9),
      .in_pub_suit  (pub_suit9),
      .out_valid    (out_valid9),
      .out_winner   (out_winner9)
`ifdef SHOWDOWN_SCORE_OUT_EN
      ,
      .out_best_score (out_best_score9)
`endif
   );

   poker_hand_eval u_chk (
      .card_num  (ev_num),
      .card_suit (ev_suit),
      .score     (ev_score)
   );

   function automatic logic [27:0] pn7(input int c0, c1, c2, c3, c4, c5, c6);
      return {4'(c6), 4'(c5), 4'(c4), 4'(c3), 4'(c2), 4'(c1), 4'(c0)};
   endfunction

   function automatic logic [13:0] ps7(input int c0, c1, c2, c3, c4, c5, c6);
      return {2'(c6), 2'(c5), 2'(c4), 2'(c3), 2'(c2), 2'(c1), 2'(c0)};
   endfunction

   function automatic logic [19:0] pn5(input int c0, c1, c2, c3, c4);
      return {4'(c4), 4'(c3), 4'(c2), 4'(c1), 4'(c0)};
   endfunction

   function automatic logic [9:0] ps5(input int c0, c1, c2, c3, c4);
      return {2'(c4), 2'(c3), 2'(c2), 2'(c1), 2'(c0)};
   endfunction

   function automatic logic [15:0] pn4(input int c0, c1, c2, c3);
      return {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
   endfunction

   function automatic logic [7:0] ps4(input int c0, c1, c2, c3);
      return {2'(c3), 2'(c2), 2'(c1), 2'(c0)};
   endfunction

   // Strobes one hand into dut2 at the current negedge and measures when the result appears.
   task automatic run_hand2(input logic [19:0] pnum, input logic [9:0] psuit,
                            input logic [15:0] hnum, input logic [7:0] hsuit,
                            output int lat, output logic [1:0] win, output logic [7:0] best,
                            output bit quiet_ok, output bit drop_ok);
      lat      = -1;
      win      = '0;
      best     = '0;
      quiet_ok = 1'b1;
      drop_ok  = 1'b0;
      pub_num2   = pnum;
      pub_suit2  = psuit;
      hole_num2  = hnum;
      hole_suit2 = hsuit;
      in_valid2  = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         in_valid2 = 1'b0;
         if (out_valid2 === 1'b1) begin
            lat = k;
            win = out_winner2;
`ifdef SHOWDOWN_SCORE_OUT_EN
            best = out_best_score2;
`endif
            break;
         end
         if (out_winner2 !== 2'b00) quiet_ok = 1'b0;
`ifdef SHOWDOWN_SCORE_OUT_EN
         if (out_best_score2 !== 8'h00) quiet_ok = 1'b0;
`endif
      end
      @(negedge clk);
      drop_ok = (out_valid2 === 1'b0) && (out_winner2 === 2'b00);
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid2 !== 1'b0 || out_winner2 !== 2'b00)
            $display("FAIL reset_dut2 cycle %0d: valid=%b winner=%b want 0/00", k, out_valid2, out_winner2);
         else n_pass++;
         n_checks++;
         if (out_valid9 !== 1'b0 || out_winner9 !== 9'h000)
            $display("FAIL reset_dut9 cycle %0d: valid=%b winner=%b want 0/000000000", k, out_valid9, out_winner9);
         else n_pass++;
      end
      rst_n = 1'b1;
   endtask

   task automatic test_royal();
      int lat; logic [1:0] win; logic [7:0] best; bit quiet_ok; bit drop_ok;
      run_hand2(pn5(1, 13, 12, 2, 3), ps5(0, 0, 0, 1, 2), pn4(11, 10, 1, 1), ps4(0, 0, 1, 2),
                lat, win, best, quiet_ok, drop_ok);
      n_checks++;
      if (lat != 3) $display("FAIL royal_latency: got %0d want 3", lat); else n_pass++;
      n_checks++;
      if (win !== 2'b01) $display("FAIL royal_winner: got %b want 01", win); else n_pass++;
      n_checks++;
      if (!quiet_ok) $display("FAIL royal_quiet: outputs nonzero while out_valid=0"); else n_pass++;
      n_checks++;
      if (!drop_ok) $display("FAIL royal_pulse: out_valid/out_winner not cleared after one cycle"); else n_pass++;
`ifdef SHOWDOWN_SCORE_OUT_EN
      n_checks++;
      if (best !== 8'h8E) $display("FAIL royal_best: got %h want 8e", best); else n_pass++;
`endif
   endtask

   task automatic test_wheel();
      int lat; logic [1:0] win; logic [7:0] best; bit quiet_ok; bit drop_ok;
      run_hand2(pn5(1, 2, 3, 9, 13), ps5(3, 2, 1, 0, 3), pn4(4, 5, 13, 13), ps4(0, 1, 2, 1),
                lat, win, best, quiet_ok, drop_ok);
      n_checks++;
      if (lat != 3) $display("FAIL wheel_latency: got %0d want 3", lat); else n_pass++;
      n_checks++;
      if (win !== 2'b01) $display("FAIL wheel_winner: got %b want 01", win); else n_pass++;
      n_checks++;
      if (!quiet_ok || !drop_ok) $display("FAIL wheel_pulse: quiet=%0b drop=%0b want 1/1", quiet_ok, drop_ok); else n_pass++;
`ifdef SHOWDOWN_SCORE_OUT_EN
      n_checks++;
      if (best !== 8'h45) $display("FAIL wheel_best: got %h want 45", best); else n_pass++;
`endif
   endtask

   task automatic test_tie();
      int lat; logic [1:0] win; logic [7:0] best; bit quiet_ok; bit drop_ok;
      run_hand2(pn5(10, 11, 12, 13, 1), ps5(3, 2, 1, 0, 3), pn4(2, 3, 4, 5), ps4(2, 1, 1, 2),
                lat, win, best, quiet_ok, drop_ok);
      n_checks++;
      if (lat != 3) $display("FAIL tie_latency: got %0d want 3", lat); else n_pass++;
      n_checks++;
      if (win !== 2'b11) $display("FAIL tie_winner: got %b want 11", win); else n_pass++;
`ifdef SHOWDOWN_SCORE_OUT_EN
      n_checks++;
      if (best !== 8'h4E) $display("FAIL tie_best: got %h want 4e", best); else n_pass++;
`endif
   endtask

   // Strobe held through DONE (must be ignored) and into the following IDLE cycle (must be taken).
   task automatic test_back_to_back();
      pub_num2   = pn5(1, 2, 3, 9, 13);
      pub_suit2  = ps5(3, 2, 1, 0, 3);
      hole_num2  = pn4(4, 5, 13, 13);
      hole_suit2 = ps4(0, 1, 2, 1);
      in_valid2  = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) in_valid2 = 1'b0;
         if (k == 3) begin
            n_checks++;
            if (out_valid2 !== 1'b1 || out_winner2 !== 2'b01)
               $display("FAIL b2b_first: valid=%b winner=%b want 1/01", out_valid2, out_winner2);
            else n_pass++;
            pub_num2   = pn5(10, 11, 12, 13, 1);
            pub_suit2  = ps5(3, 2, 1, 0, 3);
            hole_num2  = pn4(2, 3, 4, 5);
            hole_suit2 = ps4(2, 1, 1, 2);
            in_valid2  = 1'b1;
         end
         if (k == 5) in_valid2 = 1'b0;
         if (k == 6) begin
            n_checks++;
            if (out_valid2 !== 1'b0)
               $display("FAIL b2b_done_ignored: valid=%b want 0", out_valid2);
            else n_pass++;
         end
         if (k == 7) begin
            n_checks++;
            if (out_valid2 !== 1'b1 || out_winner2 !== 2'b11)
               $display("FAIL b2b_second: valid=%b winner=%b want 1/11", out_valid2, out_winner2);
            else n_pass++;
         end
      end
   endtask

   task automatic test_nine_players();
      int hr [18] = '{3,4, 3,5, 3,6, 4,6, 1,1, 5,6, 3,5, 4,5, 4,6};
      int hs [18] = '{0,1, 1,0, 2,1, 0,0, 0,1, 1,2, 3,2, 2,3, 3,3};
      int pulses;
      int first_k;
      logic [8:0] win;
      logic [7:0] best;
      pulses  = 0;
      first_k = -1;
      win     = '0;
      best    = '0;
      for (int i = 0; i < 18; i++) begin
         hole_num9[i*4 +: 4]  = 4'(hr[i]);
         hole_suit9[i*2 +: 2] = 2'(hs[i]);
      end
      pub_num9  = pn5(2, 7, 9, 11, 13);
      pub_suit9 = ps5(0, 1, 2, 3, 0);
      in_valid9 = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         if (k == 1) in_valid9 = 1'b0;
         if (k == 4) in_valid9 = 1'b1;
         if (k == 5) in_valid9 = 1'b0;
         if (out_valid9 === 1'b1) begin
            pulses++;
            if (first_k < 0) begin
               first_k = k;
               win     = out_winner9;
`ifdef SHOWDOWN_SCORE_OUT_EN
               best    = out_best_score9;
`endif
            end
         end
      end
      n_checks++;
      if (pulses != 1) $display("FAIL n9_pulses: got %0d want 1", pulses); else n_pass++;
      n_checks++;
      if (first_k != 10) $display("FAIL n9_latency: got %0d want 10", first_k); else n_pass++;
      n_checks++;
      if (win !== 9'h010) $display("FAIL n9_winner: got %b want 000010000", win); else n_pass++;
`ifdef SHOWDOWN_SCORE_OUT_EN
      n_checks++;
      if (best !== 8'h1E) $display("FAIL n9_best: got %h want 1e", best); else n_pass++;
`endif
   endtask

   task automatic test_reset_abort();
      int pulses;
      int lat; logic [1:0] win; logic [7:0] best; bit quiet_ok; bit drop_ok;
      pulses     = 0;
      pub_num2   = pn5(1, 13, 12, 2, 3);
      pub_suit2  = ps5(0, 0, 0, 1, 2);
      hole_num2  = pn4(11, 10, 1, 1);
      hole_suit2 = ps4(0, 0, 1, 2);
      in_valid2  = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) in_valid2 = 1'b0;
         if (k == 2) rst_n = 1'b0;
         if (k == 3) rst_n = 1'b1;
         if (out_valid2 === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses != 0) $display("FAIL abort_no_output: got %0d pulses want 0", pulses); else n_pass++;
      run_hand2(pn5(10, 11, 12, 13, 1), ps5(3, 2, 1, 0, 3), pn4(2, 3, 4, 5), ps4(2, 1, 1, 2),
                lat, win, best, quiet_ok, drop_ok);
      n_checks++;
      if (lat != 3) $display("FAIL abort_fresh_latency: got %0d want 3", lat); else n_pass++;
      n_checks++;
      if (win !== 2'b11) $display("FAIL abort_fresh_winner: got %b want 11", win); else n_pass++;
   endtask

   task automatic test_hand_eval();
      logic [27:0] tn [12];
      logic [13:0] ts [12];
      logic [7:0]  te [12];
      tn[0]  = pn7(1, 13, 12, 2, 3, 11, 10);  ts[0]  = ps7(0, 0, 0, 1, 2, 0, 0);  te[0]  = 8'h8E;
      tn[1]  = pn7(1, 13, 12, 2, 3, 1, 1);    ts[1]  = ps7(0, 0, 0, 1, 2, 1, 2);  te[1]  = 8'h3E;
      tn[2]  = pn7(1, 2, 3, 9, 13, 4, 5);     ts[2]  = ps7(3, 2, 1, 0, 3, 0, 1);  te[2]  = 8'h45;
      tn[3]  = pn7(1, 2, 3, 9, 13, 13, 13);   ts[3]  = ps7(3, 2, 1, 0, 3, 2, 1);  te[3]  = 8'h3D;
      tn[4]  = pn7(9, 9, 9, 4, 4, 2, 13);     ts[4]  = ps7(0, 1, 2, 0, 1, 3, 3);  te[4]  = 8'h69;
      tn[5]  = pn7(7, 7, 7, 7, 1, 13, 12);    ts[5]  = ps7(0, 1, 2, 3, 0, 0, 0);  te[5]  = 8'h77;
      tn[6]  = pn7(2, 5, 9, 11, 13, 1, 12);   ts[6]  = ps7(1, 1, 1, 1, 1, 0, 2);  te[6]  = 8'h5D;
      tn[7]  = pn7(3, 3, 8, 8, 12, 5, 6);     ts[7]  = ps7(0, 1, 0, 2, 3, 0, 1);  te[7]  = 8'h28;
      tn[8]  = pn7(2, 4, 6, 8, 10, 12, 13);   ts[8]  = ps7(0, 1, 2, 3, 0, 1, 2);  te[8]  = 8'h0D;
      tn[9]  = pn7(2, 2, 5, 7, 9, 11, 13);    ts[9]  = ps7(0, 1, 2, 3, 0, 1, 2);  te[9]  = 8'h12;
      tn[10] = pn7(1, 2, 3, 4, 5, 9, 13);     ts[10] = ps7(0, 0, 0, 0, 0, 1, 2);  te[10] = 8'h85;
      tn[11] = pn7(5, 5, 5, 12, 12, 12, 3);   ts[11] = ps7(0, 1, 2, 0, 1, 2, 3);  te[11] = 8'h6C;
      for (int i = 0; i < 12; i++) begin
         ev_num  = tn[i];
         ev_suit = ts[i];
         #1;
         n_checks++;
         if (ev_score !== te[i]) $display("FAIL eval_hand_%0d: got %h want %h", i, ev_score, te[i]);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_royal();
      test_wheel();
      test_tie();
      test_back_to_back();
      test_nine_players();
      test_reset_abort();
      test_hand_eval();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
